// File: rtl/sumador_pkg.sv
// Shared mode encoding and default widths for the sumador accumulator block.
package sumador_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_ACC_WIDTH = 8;

endpackage

// File: rtl/sumador_core.sv
// Combinational N-bit adder with carry-in and carry-out.
module sumador_core #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/sumador_acc.sv
// Add/sub/accumulate/clear unit with valid/ready input and a one-deep registered output.
// Optional macro SUMADOR_SATURATE_EN makes ACC saturate high and SUB saturate at zero.
module sumador_acc
  import sumador_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 cin,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 cout,
  output logic                 overflow
);

  mode_e                 mode_s;
  logic                  accept;
  logic [WIDTH-1:0]      as_b;
  logic                  as_cin;
  logic [WIDTH-1:0]      as_sum;
  logic                  as_cout;
  logic [ACC_WIDTH-1:0]  acc_b;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic                  acc_cout;

  logic                  vld_q, vld_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  res_q, res_d;
  logic                  cout_q, cout_d;
  logic                  ovf_q, ovf_d;

`ifdef SUMADOR_SATURATE_EN
  function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [ACC_WIDTH-1:0] v,
                                                   input logic carry);
    return carry ? '1 : v;
  endfunction

  function automatic logic [ACC_WIDTH-1:0] sat_sub(input logic [ACC_WIDTH-1:0] v,
                                                   input logic no_borrow);
    return no_borrow ? v : '0;
  endfunction
`endif

  assign mode_s   = mode_e'(mode);
  assign in_ready = !vld_q | out_ready;
  assign accept   = in_valid & in_ready;

  // SUB is A + ~B + !borrow_in on the shared WIDTH-bit adder
  assign as_b   = (mode_s == MODE_SUB) ? ~op_b : op_b;
  assign as_cin = (mode_s == MODE_SUB) ? ~cin : cin;
  assign acc_b  = ACC_WIDTH'(op_a);

  sumador_core #(.N(WIDTH)) u_addsub (
    .a_i    (op_a),
    .b_i    (as_b),
    .cin_i  (as_cin),
    .sum_o  (as_sum),
    .cout_o (as_cout)
  );

  sumador_core #(.N(ACC_WIDTH)) u_accum (
    .a_i    (acc_q),
    .b_i    (acc_b),
    .cin_i  (cin),
    .sum_o  (acc_sum),
    .cout_o (acc_cout)
  );

  always_comb begin
    vld_d  = vld_q;
    acc_d  = acc_q;
    res_d  = res_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      vld_d = 1'b1;
      unique case (mode_s)
        MODE_ADD: begin
          res_d  = ACC_WIDTH'({as_cout, as_sum});
          cout_d = as_cout;
          ovf_d  = 1'b0;
        end
        MODE_SUB: begin
          cout_d = as_cout;
`ifdef SUMADOR_SATURATE_EN
          res_d  = sat_sub(ACC_WIDTH'(as_sum), as_cout);
          ovf_d  = ~as_cout;
`else
          res_d  = ACC_WIDTH'(as_sum);
          ovf_d  = 1'b0;
`endif
        end
        MODE_ACC: begin
`ifdef SUMADOR_SATURATE_EN
          acc_d  = sat_acc(acc_sum, acc_cout);
`else
          acc_d  = acc_sum;
`endif
          res_d  = acc_d;
          cout_d = acc_cout;
          ovf_d  = acc_cout;
        end
        MODE_CLR: begin
          acc_d  = '0;
          res_d  = '0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
        end
      endcase
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  // Output/accumulator register stage; reset drops any in-flight accept
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      acc_q  <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sumador_acc.sv
// Self-checking bench for sumador_acc against an arithmetic reference model.
module tb_sumador_acc;

  localparam int W  = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          cin = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] result;
  logic          cout;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int acc_m  = 0;

  logic [AW-1:0] exp_res;
  logic          exp_cout;
  logic          exp_ovf;

  sumador_acc #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the mode rules
  task automatic model(input int m, input int a, input int b, input int c);
    int s;
    case (m)
      0: begin
        s = a + b + c;
        exp_res = AW'(s); exp_cout = (s >= (1 << W)); exp_ovf = 1'b0;
      end
      1: begin
        s = a - b - c;
        exp_cout = (s >= 0);
        exp_res  = (s >= 0) ? AW'(s) : AW'(s + (1 << W));
        exp_ovf  = 1'b0;
`ifdef SUMADOR_SATURATE_EN
        if (s < 0) begin exp_res = '0; exp_ovf = 1'b1; end
`endif
      end
      2: begin
        s = acc_m + a + c;
        exp_cout = (s >= (1 << AW));
        exp_ovf  = exp_cout;
`ifdef SUMADOR_SATURATE_EN
        acc_m = exp_cout ? (1 << AW) - 1 : s;
`else
        acc_m = s % (1 << AW);
`endif
        exp_res = AW'(acc_m);
      end
      default: begin
        acc_m = 0; exp_res = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
      end
    endcase
  endtask

  task automatic check_out(input string name);
    checks++;
    if (out_valid !== 1'b1 || result !== exp_res || cout !== exp_cout || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s: got vld=%b res=%h cout=%b ovf=%b, want vld=1 res=%h cout=%b ovf=%b",
               name, out_valid, result, cout, overflow, exp_res, exp_cout, exp_ovf);
    end
  endtask

  // One accepted operation with out_ready=1, checked the cycle after
  task automatic do_op(input int m, input int a, input int b, input int c, input string name);
    @(negedge clk);
    mode = 2'(m); op_a = W'(a); op_b = W'(b); cin = c[0];
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(m, a, b, c);
    check_out(name);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got vld=%b res=%h cout=%b ovf=%b want all 0",
               out_valid, result, cout, overflow);
    end
    reset = 1'b0;
    acc_m = 0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    do_op(2, 0, 0, 0, "reset_acc_zero");
  endtask

  task automatic test_add;
    do_op(0, 9, 8, 1, "add_9_8_1");
    do_op(0, 0, 0, 0, "add_0_0_0");
    do_op(0, 15, 15, 1, "add_max");
  endtask

  task automatic test_sub;
    do_op(1, 3, 5, 0, "sub_3_5_0");
    do_op(1, 7, 2, 1, "sub_7_2_1");
    do_op(1, 0, 0, 1, "sub_0_0_1");
  endtask

  task automatic test_backpressure;
    logic [AW-1:0] held;
    do_op(0, 6, 5, 0, "bp_first");
    held = exp_res;
    @(negedge clk);
    out_ready = 1'b0;
    mode = 2'b00; op_a = 4'd1; op_b = 4'd1; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== held) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%b res=%h want vld=1 res=%h", i, out_valid, result, held);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(0, 1, 1, 0);
    check_out("bp_accept_after_stall");
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || result !== exp_res) begin
      errors++;
      $display("FAIL bp_drain: got vld=%b res=%h want vld=0 res=%h", out_valid, result, exp_res);
    end
  endtask

  task automatic test_acc_wrap;
    do_op(3, 0, 0, 0, "clr");
    for (int i = 0; i < 16; i++) do_op(2, 15, 0, 0, "acc_15");
    checks++;
    if (result !== 8'd240) begin
      errors++;
      $display("FAIL acc_240: got %h want f0", result);
    end
    do_op(2, 15, 0, 1, "acc_wrap");
    do_op(2, 1, 0, 0, "acc_after_wrap");
    do_op(3, 0, 0, 0, "clr_end");
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), "rand_op");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle: got vld=%b want 0", out_valid);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    do_op(0, 1, 2, 0, "b2b_0");
    do_op(0, 3, 4, 1, "b2b_1");
    do_op(0, 8, 8, 0, "b2b_2");
    do_op(0, 15, 1, 0, "b2b_3");
    do_op(2, 5, 0, 0, "b2b_acc");
    do_op(0, 2, 2, 0, "b2b_pre_reset");
    @(negedge clk);
    mode = 2'b10; op_a = 4'd9; cin = 1'b1; in_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b0;
    acc_m = 0;
    checks++;
    if (out_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: got vld=%b res=%h want vld=0 res=00", out_valid, result);
    end
    do_op(2, 0, 0, 0, "acc_after_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_acc_wrap();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
